// File: rtl/mem_access_if.sv
// Bundles the command, data-memory handshake and result signals of the load/store sequencer.
// The slave modport is the sequencer; master is the control unit plus data memory.
interface mem_access_if #(
    parameter int unsigned DATA_W = 16
);
    logic              start;
    logic              is_store;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    logic [DATA_W-1:0] rdata;
    logic              done;
    logic              err;
    logic              busy;

    modport slave (
        input  start, is_store, addr, wdata, mem_rdata, mem_ack,
        output mem_req, mem_we, mem_addr, mem_wdata, rdata, done, err, busy
    );

    modport master (
        output start, is_store, addr, wdata, mem_rdata, mem_ack,
        input  mem_req, mem_we, mem_addr, mem_wdata, rdata, done, err, busy
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store sequencer for the data-memory port: one command at a time, req/ack handshake,
// bounded wait with abort, and a held copy of the last successfully loaded word.
module mem_access_unit #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    mem_access_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t            state;
    logic [7:0]        cnt;
    logic              req_q;
    logic              we_q;
    logic              done_q;
    logic              err_q;
    logic              busy_q;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    err_q  <= 1'b0;
                    if (bus.start) begin
                        addr_q  <= bus.addr;
                        wdata_q <= bus.wdata;
                        we_q    <= bus.is_store;
                        cnt     <= '0;
                        req_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    // Ack takes priority over the timeout check in the same cycle.
                    if (bus.mem_ack) begin
                        if (!we_q) begin
                            rdata_q <= bus.mem_rdata;
                        end
                        req_q  <= 1'b0;
                        we_q   <= 1'b0;
                        done_q <= 1'b1;
                        err_q  <= 1'b0;
                        state  <= DONE;
                    end else if (cnt == CNT_LAST) begin
                        req_q  <= 1'b0;
                        we_q   <= 1'b0;
                        done_q <= 1'b1;
                        err_q  <= 1'b1;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    err_q  <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    req_q  <= 1'b0;
                    we_q   <= 1'b0;
                    done_q <= 1'b0;
                    err_q  <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_req   = req_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.rdata     = rdata_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.busy      = busy_q;
endmodule
